// File: rtl/cache_line_ctrl_if.sv
// ============================================================================
// cache_line_ctrl_if
// Bus bundle between the line-transfer sequencer, the L1 data array and memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface cache_line_ctrl_if #(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
);
  localparam int IW = $clog2(LINE_WORDS);

  logic              miss_i;
  logic              dirty_i;
  logic [31:0]       miss_addr_i;
  logic [31:0]       victim_addr_i;
  logic [31:0]       line_rdata_i;
  logic [IW-1:0]     line_word_o;
  logic              line_we_o;
  logic [31:0]       line_wdata_o;
  logic [31:0]       mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [31:0]       mem_rdata_i;
  logic              mem_ack_i;
  logic              tag_we_o;
  logic              done_o;
  logic              busy_o;
  logic [CNT_W-1:0]  fill_cnt_o;
  logic [CNT_W-1:0]  wb_cnt_o;

  // master: the sequencer; slave: the L1/memory side
  modport master (
    input  miss_i, dirty_i, miss_addr_i, victim_addr_i, line_rdata_i,
           mem_rdata_i, mem_ack_i,
    output line_word_o, line_we_o, line_wdata_o, mem_addr_o, mem_wdata_o,
           mem_we_o, mem_re_o, tag_we_o, done_o, busy_o, fill_cnt_o, wb_cnt_o
  );

  modport slave (
    output miss_i, dirty_i, miss_addr_i, victim_addr_i, line_rdata_i,
           mem_rdata_i, mem_ack_i,
    input  line_word_o, line_we_o, line_wdata_o, mem_addr_o, mem_wdata_o,
           mem_we_o, mem_re_o, tag_we_o, done_o, busy_o, fill_cnt_o, wb_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/cache_line_ctrl.sv
// ============================================================================
// cache_line_ctrl
// Miss sequencer: dirty-victim writeback, word-by-word line fill, tag commit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_line_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 16
) (
  input  wire logic         CLK,
  input  wire logic         CLR_N,
  cache_line_ctrl_if.master bus
);
  localparam int              c_IW        = $clog2(LINE_WORDS);
  localparam logic [31:0]     c_BASE_MASK = ~32'(LINE_WORDS * 4 - 1);
  localparam logic [c_IW-1:0] c_K_LAST    = c_IW'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WB     = 2'd1,
    S_FILL   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [c_IW-1:0]  r_k, w_k_nxt;
  logic [31:0]      r_miss_base, w_miss_base_nxt;
  logic [31:0]      r_victim_base, w_victim_base_nxt;
  logic [CNT_W-1:0] r_fill_cnt, w_fill_cnt_nxt;
  logic [CNT_W-1:0] r_wb_cnt, w_wb_cnt_nxt;
  logic [31:0]      w_word_off;

  // Bases are line-aligned, so adding the word offset never carries past the line
  assign w_word_off = {{(30 - c_IW){1'b0}}, r_k, 2'b00};

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_miss_base   <= '0;
      r_victim_base <= '0;
      r_fill_cnt    <= '0;
      r_wb_cnt      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_k           <= w_k_nxt;
      r_miss_base   <= w_miss_base_nxt;
      r_victim_base <= w_victim_base_nxt;
      r_fill_cnt    <= w_fill_cnt_nxt;
      r_wb_cnt      <= w_wb_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_k_nxt           = r_k;
    w_miss_base_nxt   = r_miss_base;
    w_victim_base_nxt = r_victim_base;
    w_fill_cnt_nxt    = r_fill_cnt;
    w_wb_cnt_nxt      = r_wb_cnt;
    bus.line_word_o   = '0;
    bus.line_we_o     = 1'b0;
    bus.line_wdata_o  = '0;
    bus.mem_addr_o    = '0;
    bus.mem_wdata_o   = '0;
    bus.mem_we_o      = 1'b0;
    bus.mem_re_o      = 1'b0;
    bus.tag_we_o      = 1'b0;
    bus.done_o        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.miss_i) begin
          w_miss_base_nxt   = bus.miss_addr_i & c_BASE_MASK;
          w_victim_base_nxt = bus.victim_addr_i & c_BASE_MASK;
          w_k_nxt           = '0;
          w_state_nxt       = bus.dirty_i ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = r_victim_base + w_word_off;
        bus.line_word_o = r_k;
        bus.mem_wdata_o = bus.line_rdata_i;
        if (bus.mem_ack_i) begin
          if (r_k == c_K_LAST) begin
            w_k_nxt      = '0;
            w_wb_cnt_nxt = (r_wb_cnt == c_CNT_MAX) ? r_wb_cnt : r_wb_cnt + CNT_W'(1);
            w_state_nxt  = S_FILL;
          end else begin
            w_k_nxt = r_k + c_IW'(1);
          end
        end
      end
      S_FILL: begin
        bus.mem_re_o    = 1'b1;
        bus.mem_addr_o  = r_miss_base + w_word_off;
        bus.line_word_o = r_k;
        if (bus.mem_ack_i) begin
          bus.line_we_o    = 1'b1;
          bus.line_wdata_o = bus.mem_rdata_i;
          if (r_k == c_K_LAST) begin
            w_k_nxt     = '0;
            w_state_nxt = S_COMMIT;
          end else begin
            w_k_nxt = r_k + c_IW'(1);
          end
        end
      end
      S_COMMIT: begin
        bus.tag_we_o   = 1'b1;
        bus.done_o     = 1'b1;
        w_fill_cnt_nxt = (r_fill_cnt == c_CNT_MAX) ? r_fill_cnt : r_fill_cnt + CNT_W'(1);
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy_o     = (r_state != S_IDLE);
  assign bus.fill_cnt_o = r_fill_cnt;
  assign bus.wb_cnt_o   = r_wb_cnt;

endmodule

`default_nettype wire
